// File: rtl/mem_xfer_ctrl.sv
// mem_xfer_ctrl: block-transfer sequencer for the memory stage.
// Moves N words SRAM<->RF one per cycle with a bus-float cycle each side.
module mem_xfer_ctrl #(
  parameter int ADRX_W   = 11,
  parameter int RF_DEPTH = 32,
  parameter int CNT_W    = 6
) (
  input  logic                        clk,
  input  logic                        nRst,
  input  logic                        start,
  input  logic                        dir,
  input  logic [ADRX_W-1:0]           sramBase,
  input  logic [$clog2(RF_DEPTH)-1:0] rfBase,
  input  logic [CNT_W-1:0]            count,
  input  logic                        abort,
  output logic [ADRX_W-1:0]           sramAdrx,
  output logic                        sramNotOutEn,
  output logic                        sramRead,
  output logic [RF_DEPTH-1:0]         rfWriteAdrx,
  output logic [RF_DEPTH-1:0]         rfRdAdrx0,
  output logic                        rfWriteEn,
  output logic [1:0]                  dataMuxSel,
  output logic                        busy,
  output logic                        done
);

  localparam int RF_W = $clog2(RF_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    TURN
  } state_t;

  state_t              state_q, state_d;
  logic                dir_q, dir_d;
  logic [ADRX_W-1:0]   s_adr_q, s_adr_d;
  logic [RF_W-1:0]     r_idx_q, r_idx_d;
  logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;

  logic [ADRX_W-1:0]   sram_adrx_q, sram_adrx_d;
  logic                n_oe_q, n_oe_d;
  logic                sram_rd_q, sram_rd_d;
  logic [RF_DEPTH-1:0] wr_oh_q, wr_oh_d;
  logic [RF_DEPTH-1:0] rd_oh_q, rd_oh_d;
  logic                rf_we_q, rf_we_d;
  logic [1:0]          mux_sel_q, mux_sel_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                present;
  logic [RF_DEPTH-1:0] idx_oh;

  assign idx_oh = RF_DEPTH'(1) << r_idx_q;

  // Next state, and the registered strobes for the word presented next cycle.
  // s_adr/r_idx point at the next word; word_cnt counts words not yet presented.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    s_adr_d     = s_adr_q;
    r_idx_d     = r_idx_q;
    word_cnt_d  = word_cnt_q;
    sram_adrx_d = sram_adrx_q;
    wr_oh_d     = wr_oh_q;
    rd_oh_d     = rd_oh_q;
    n_oe_d      = 1'b1;
    sram_rd_d   = 1'b1;
    rf_we_d     = 1'b0;
    mux_sel_d   = 2'd0;
    done_d      = 1'b0;
    present     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SETUP;
          dir_d      = dir;
          s_adr_d    = sramBase;
          r_idx_d    = rfBase;
          word_cnt_d = count;
        end
      end
      SETUP: begin
        if (word_cnt_q == '0 || abort) begin
          state_d = TURN;
        end else begin
          state_d = XFER;
          present = 1'b1;
        end
      end
      XFER: begin
        if (word_cnt_q == '0 || abort) begin
          state_d = TURN;
        end else begin
          present = 1'b1;
        end
      end
      TURN: begin
        state_d     = IDLE;
        done_d      = 1'b1;
        sram_adrx_d = '0;
        wr_oh_d     = RF_DEPTH'(1);
        rd_oh_d     = RF_DEPTH'(1);
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (present) begin
      sram_adrx_d = s_adr_q;
      s_adr_d     = s_adr_q + ADRX_W'(1);
      word_cnt_d  = word_cnt_q - CNT_W'(1);
      if (r_idx_q == RF_W'(RF_DEPTH - 1)) begin
        r_idx_d = '0;
      end else begin
        r_idx_d = r_idx_q + RF_W'(1);
      end
      if (dir_q) begin
        sram_rd_d = 1'b0;
        mux_sel_d = 2'd3;
        rd_oh_d   = idx_oh;
      end else begin
        n_oe_d  = 1'b0;
        rf_we_d = 1'b1;
        wr_oh_d = idx_oh;
      end
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset forces the bus-safe values at once.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= IDLE;
      dir_q       <= 1'b0;
      s_adr_q     <= '0;
      r_idx_q     <= '0;
      word_cnt_q  <= '0;
      sram_adrx_q <= '0;
      n_oe_q      <= 1'b1;
      sram_rd_q   <= 1'b1;
      wr_oh_q     <= RF_DEPTH'(1);
      rd_oh_q     <= RF_DEPTH'(1);
      rf_we_q     <= 1'b0;
      mux_sel_q   <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      s_adr_q     <= s_adr_d;
      r_idx_q     <= r_idx_d;
      word_cnt_q  <= word_cnt_d;
      sram_adrx_q <= sram_adrx_d;
      n_oe_q      <= n_oe_d;
      sram_rd_q   <= sram_rd_d;
      wr_oh_q     <= wr_oh_d;
      rd_oh_q     <= rd_oh_d;
      rf_we_q     <= rf_we_d;
      mux_sel_q   <= mux_sel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign sramAdrx     = sram_adrx_q;
  assign sramNotOutEn = n_oe_q;
  assign sramRead     = sram_rd_q;
  assign rfWriteAdrx  = wr_oh_q;
  assign rfRdAdrx0    = rd_oh_q;
  assign rfWriteEn    = rf_we_q;
  assign dataMuxSel   = mux_sel_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// tb_mem_xfer_ctrl: random and directed transfers against a
// per-cycle expected-output timeline built from the transfer rules.
module tb_mem_xfer_ctrl;

  localparam int AW = 11;
  localparam int RD = 32;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          nRst = 1'b1;
  logic          start = 1'b0;
  logic          dir = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] sram_base = '0;
  logic [4:0]    rf_base = '0;
  logic [CW-1:0] count = '0;

  logic [AW-1:0] sram_adrx;
  logic          sram_n_oe;
  logic          sram_read;
  logic [RD-1:0] rf_wr_adrx;
  logic [RD-1:0] rf_rd_adrx0;
  logic          rf_we;
  logic [1:0]    mux_sel;
  logic          busy;
  logic          done;

  mem_xfer_ctrl #(.ADRX_W(AW), .RF_DEPTH(RD), .CNT_W(CW)) dut (
    .clk(clk), .nRst(nRst), .start(start), .dir(dir),
    .sramBase(sram_base), .rfBase(rf_base), .count(count),
    .abort(abort), .sramAdrx(sram_adrx),
    .sramNotOutEn(sram_n_oe), .sramRead(sram_read),
    .rfWriteAdrx(rf_wr_adrx), .rfRdAdrx0(rf_rd_adrx0),
    .rfWriteEn(rf_we), .dataMuxSel(mux_sel),
    .busy(busy), .done(done)
  );

  typedef struct packed {
    logic          busy;
    logic          done;
    logic [AW-1:0] adr;
    logic [RD-1:0] wr_oh;
    logic [RD-1:0] rd_oh;
    logic          we;
    logic          n_oe;
    logic          rd;
    logic [1:0]    mux;
  } obs_t;

  obs_t exp_q [int];
  obs_t cap [int];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic obs_t idle_obs();
    obs_t e;
    e = '0;
    e.wr_oh = RD'(1);
    e.rd_oh = RD'(1);
    e.n_oe  = 1'b1;
    e.rd    = 1'b1;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h",
               name, cyc, act, req);
    end
  endtask

  // Per-cycle comparison of every output against the timeline.
  always @(negedge clk) begin : cmp
    obs_t a;
    obs_t e;
    if (chk_en) begin
      a.busy  = busy;
      a.done  = done;
      a.adr   = sram_adrx;
      a.wr_oh = rf_wr_adrx;
      a.rd_oh = rf_rd_adrx0;
      a.we    = rf_we;
      a.n_oe  = sram_n_oe;
      a.rd    = sram_read;
      a.mux   = mux_sel;
      cap[cyc] = a;
      e = exp_q.exists(cyc) ? exp_q[cyc] : idle_obs();
      if (exp_q.exists(cyc)) exp_q.delete(cyc);
      check("busy", 64'(a.busy), 64'(e.busy));
      check("done", 64'(a.done), 64'(e.done));
      check("sramAdrx", 64'(a.adr), 64'(e.adr));
      check("rfWriteAdrx", 64'(a.wr_oh), 64'(e.wr_oh));
      check("rfRdAdrx0", 64'(a.rd_oh), 64'(e.rd_oh));
      check("rfWriteEn", 64'(a.we), 64'(e.we));
      check("sramNotOutEn", 64'(a.n_oe), 64'(e.n_oe));
      check("sramRead", 64'(a.rd), 64'(e.rd));
      check("dataMuxSel", 64'(a.mux), 64'(e.mux));
      check("bus_conflict", 64'(a.mux == 2'd3 && !a.n_oe), 64'(0));
      check("done_and_busy", 64'(a.done && a.busy), 64'(0));
    end
  end

  // Issue one command at the current negedge and run it to its done cycle.
  // abort_at: cycle offset after the start edge (1 = SETUP), 0 = none.
  task automatic xfer(input logic d, input logic [AW-1:0] sb,
                      input logic [4:0] rb, input int n_cnt,
                      input int abort_at, output int c0);
    int   c;
    int   n;
    obs_t e;
    c  = cyc;
    c0 = c;
    start     = 1'b1;
    dir       = d;
    sram_base = sb;
    rf_base   = rb;
    count     = CW'(n_cnt);
    abort     = 1'b0;
    n = n_cnt;
    if (abort_at == 1) n = 0;
    else if (abort_at >= 2 && abort_at <= n_cnt + 1) n = abort_at - 1;
    e = idle_obs();
    e.busy = 1'b1;
    exp_q[c+1] = e;
    for (int i = 1; i <= n; i++) begin
      int ri;
      ri = (int'(rb) + i - 1) % RD;
      e = idle_obs();
      e.busy = 1'b1;
      e.adr  = AW'(int'(sb) + i - 1);
      if (!d) begin
        e.n_oe  = 1'b0;
        e.we    = 1'b1;
        e.wr_oh = RD'(1) << ri;
      end else begin
        e.rd    = 1'b0;
        e.mux   = 2'd3;
        e.rd_oh = RD'(1) << ri;
      end
      exp_q[c+1+i] = e;
    end
    if (n > 0) e = exp_q[c+1+n];
    else e = idle_obs();
    e.busy = 1'b1;
    e.we   = 1'b0;
    e.n_oe = 1'b1;
    e.rd   = 1'b1;
    e.mux  = 2'd0;
    exp_q[c+n+2] = e;
    e = idle_obs();
    e.done = 1'b1;
    exp_q[c+n+3] = e;
    for (int k = 1; k <= n + 2; k++) begin
      @(negedge clk);
      start     = 1'($urandom_range(0, 1));
      dir       = 1'($urandom);
      sram_base = AW'($urandom);
      rf_base   = 5'($urandom);
      count     = CW'($urandom);
      abort     = (k == abort_at);
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    #5_000_000;
    failures++;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int c;
    int c2;
    int wr_cnt;
    int n;
    int ab;
    int gap;
    logic [AW-1:0] t2_adr [4];
    logic [RD-1:0] t2_oh [4];
    logic [AW-1:0] t3_adr [4];
    logic [RD-1:0] t3_oh [4];
    t2_adr = '{11'h010, 11'h011, 11'h012, 11'h013};
    t2_oh  = '{32'h8, 32'h10, 32'h20, 32'h40};
    t3_adr = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
    t3_oh  = '{32'h4000_0000, 32'h8000_0000, 32'h1, 32'h2};

    #1 nRst = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_adr", 64'(sram_adrx), 64'(0));
    check("rst_wr_oh", 64'(rf_wr_adrx), 64'(1));
    check("rst_rd_oh", 64'(rf_rd_adrx0), 64'(1));
    check("rst_mux", 64'(mux_sel), 64'(0));
    check("rst_noe", 64'(sram_n_oe), 64'(1));
    repeat (2) @(negedge clk);
    nRst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    xfer(1'b0, 11'h010, 5'd3, 4, 0, c);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t2_adr", 64'(cap[c+2+i].adr), 64'(t2_adr[i]));
      check("t2_wr_oh", 64'(cap[c+2+i].wr_oh), 64'(t2_oh[i]));
      check("t2_we", 64'(cap[c+2+i].we), 64'(1));
    end
    check("t2_busy6", 64'(cap[c+6].busy), 64'(1));
    check("t2_done7", 64'(cap[c+7].done), 64'(1));
    check("t2_busy7", 64'(cap[c+7].busy), 64'(0));
    repeat (2) @(negedge clk);

    xfer(1'b1, 11'h7FE, 5'd30, 4, 0, c);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t3_adr", 64'(cap[c+2+i].adr), 64'(t3_adr[i]));
      check("t3_rd_oh", 64'(cap[c+2+i].rd_oh), 64'(t3_oh[i]));
      check("t3_mux", 64'(cap[c+2+i].mux), 64'(3));
      check("t3_read", 64'(cap[c+2+i].rd), 64'(0));
    end
    @(negedge clk);

    xfer(1'b0, 11'h155, 5'd9, 0, 0, c);
    #1;
    check("t4_busy1", 64'(cap[c+1].busy), 64'(1));
    check("t4_busy2", 64'(cap[c+2].busy), 64'(1));
    check("t4_done3", 64'(cap[c+3].done), 64'(1));
    check("t4_we", 64'(cap[c+1].we | cap[c+2].we), 64'(0));
    check("t4_noe", 64'(cap[c+1].n_oe & cap[c+2].n_oe), 64'(1));
    @(negedge clk);

    xfer(1'b0, 11'h100, 5'd2, 8, 3, c);
    #1;
    wr_cnt = 0;
    for (int i = 1; i <= 5; i++) wr_cnt += int'(cap[c+i].we);
    check("t5_writes", 64'(wr_cnt), 64'(2));
    check("t5_turn", 64'(cap[c+4].busy), 64'(1));
    check("t5_done", 64'(cap[c+5].done), 64'(1));
    @(negedge clk);

    xfer(1'b1, 11'h3FF, 5'd31, 3, 0, c);
    xfer(1'b0, 11'h001, 5'd0, 2, 0, c2);
    #1;
    check("t6_chain_at", 64'(c2 - c), 64'(6));
    check("t6_chain_busy", 64'(cap[c2+1].busy), 64'(1));
    check("t6_chain_we", 64'(cap[c2+2].we), 64'(1));
    @(negedge clk);

    repeat (150) begin
      n  = $urandom_range(0, 63);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n + 2) : 0;
      xfer(1'($urandom), AW'($urandom), 5'($urandom), n, ab, c);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(negedge clk);
        abort = 1'($urandom);
      end
    end
    abort = 1'b0;
    repeat (2) @(negedge clk);

    chk_en    = 1'b0;
    start     = 1'b1;
    dir       = 1'b1;
    sram_base = 11'h123;
    rf_base   = 5'd4;
    count     = 6'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("t1_storing", 64'(mux_sel), 64'(3));
    @(posedge clk);
    #2 nRst = 1'b0;
    #1;
    check("t1_mux", 64'(mux_sel), 64'(0));
    check("t1_read", 64'(sram_read), 64'(1));
    check("t1_noe", 64'(sram_n_oe), 64'(1));
    check("t1_busy", 64'(busy), 64'(0));
    check("t1_done", 64'(done), 64'(0));
    exp_q.delete();
    @(negedge clk);
    nRst = 1'b1;
    chk_en = 1'b1;
    repeat (4) @(negedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
